// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: hazard FSM states, forwarding select codes, drain length.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_LD_STALL,
      ST_MEM_WAIT,
      ST_DRAIN,
      ST_HALTED
   } hz_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [1:0] DRAIN_CYCLES = 2'd3;
   localparam int         NUM_SRC      = 2;

   // r0 is hardwired zero, so it can never create or satisfy a dependency.
   function automatic logic reg_hit(input logic vld, input logic [4:0] src, input logic [4:0] dst);
      return vld && (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-state inputs and stall/flush/forward controls of the hazard controller.
interface pipeline_hazard_ctrl_if;
   import cpu_pkg::*;

   logic [4:0] ID_src_reg1, ID_src_reg2;
   logic       ID_use_src1, ID_use_src2, ID_hlt;
   logic [4:0] EX_src_reg1, EX_src_reg2;
   logic [4:0] EX_dst_reg, MEM_dst_reg, WB_dst_reg;
   logic       EX_use_dst_reg, MEM_use_dst_reg, WB_use_dst_reg;
   logic       EX_mem_read, EX_branch_taken, mem_busy;
   logic       stall_IF_ID, stall_ID_EX;
   logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
   logic       pipe_hold, halted;
   logic [1:0] fwd_sel1, fwd_sel2;

   modport master (
      output ID_src_reg1, ID_src_reg2, ID_use_src1, ID_use_src2, ID_hlt,
             EX_src_reg1, EX_src_reg2, EX_dst_reg, MEM_dst_reg, WB_dst_reg,
             EX_use_dst_reg, MEM_use_dst_reg, WB_use_dst_reg,
             EX_mem_read, EX_branch_taken, mem_busy,
      input  stall_IF_ID, stall_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
             pipe_hold, halted, fwd_sel1, fwd_sel2
   );

   modport slave (
      input  ID_src_reg1, ID_src_reg2, ID_use_src1, ID_use_src2, ID_hlt,
             EX_src_reg1, EX_src_reg2, EX_dst_reg, MEM_dst_reg, WB_dst_reg,
             EX_use_dst_reg, MEM_use_dst_reg, WB_use_dst_reg,
             EX_mem_read, EX_branch_taken, mem_busy,
      output stall_IF_ID, stall_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
             pipe_hold, halted, fwd_sel1, fwd_sel2
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Per-operand forwarding select: the youngest matching producer (MEM) wins over WB.
module fwd_unit
   import cpu_pkg::*;
(
   input  logic       en,
   input  logic [4:0] ex_src,
   input  logic [4:0] mem_dst,
   input  logic       mem_wr,
   input  logic [4:0] wb_dst,
   input  logic       wb_wr,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (en) begin
         if (reg_hit(mem_wr, ex_src, mem_dst))
            sel = FWD_MEM;
         else if (reg_hit(wb_wr, ex_src, wb_dst))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use/RAW stalls, branch flush, memory wait, halt drain.
// Build option: FORWARDING_EN enables EX operand forwarding; without it RAW hazards on EX/MEM stall instead.
module pipeline_hazard_ctrl
   import cpu_pkg::*;
(
   input logic                   clk,
   input logic                   rst_n,
   pipeline_hazard_ctrl_if.slave hz
);

`ifdef FORWARDING_EN
   localparam logic FWD_ON = 1'b1;
`else
   localparam logic FWD_ON = 1'b0;
`endif

   hz_state_e state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       init_done;
   logic       ld_use, raw_haz;

   logic [NUM_SRC-1:0][4:0] id_src, ex_src;
   logic [NUM_SRC-1:0]      id_use;
   logic [NUM_SRC-1:0][1:0] sel;

   assign id_src = {hz.ID_src_reg2, hz.ID_src_reg1};
   assign id_use = {hz.ID_use_src2, hz.ID_use_src1};
   assign ex_src = {hz.EX_src_reg2, hz.EX_src_reg1};

   genvar i;
   generate
      for (i = 0; i < NUM_SRC; i++) begin : g_fwd
         fwd_unit u_fwd (
            .en      (FWD_ON),
            .ex_src  (ex_src[i]),
            .mem_dst (hz.MEM_dst_reg),
            .mem_wr  (hz.MEM_use_dst_reg),
            .wb_dst  (hz.WB_dst_reg),
            .wb_wr   (hz.WB_use_dst_reg),
            .sel     (sel[i])
         );
      end
   endgenerate

   assign hz.fwd_sel1 = sel[0];
   assign hz.fwd_sel2 = sel[1];

   // Without forwarding, any EX/MEM producer blocks the consumer; WB writes through the regfile.
   always_comb begin
      ld_use  = 1'b0;
      raw_haz = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         ld_use  |= hz.EX_mem_read & reg_hit(hz.EX_use_dst_reg & id_use[k], id_src[k], hz.EX_dst_reg);
         raw_haz |= ~FWD_ON & (reg_hit(hz.EX_use_dst_reg & id_use[k], id_src[k], hz.EX_dst_reg) |
                               reg_hit(hz.MEM_use_dst_reg & id_use[k], id_src[k], hz.MEM_dst_reg));
      end
   end

   assign hz.flush_EX_MEM = rst_n & ~init_done;
   assign hz.flush_MEM_WB = rst_n & ~init_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         cnt       <= 2'd0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         init_done <= 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      hz.stall_IF_ID = 1'b0;
      hz.stall_ID_EX = 1'b0;
      hz.flush_IF_ID = 1'b0;
      hz.flush_ID_EX = 1'b0;
      hz.pipe_hold   = 1'b0;
      hz.halted      = 1'b0;
      if (rst_n) begin
         case (state)
            ST_RUN: begin
               if (hz.mem_busy) begin
                  hz.pipe_hold = 1'b1;
                  state_nxt    = ST_MEM_WAIT;
               end else if (hz.EX_branch_taken) begin
                  // ID holds a wrong-path instruction: its halt or hazard is irrelevant.
                  hz.flush_IF_ID = 1'b1;
                  hz.flush_ID_EX = 1'b1;
               end else if (hz.ID_hlt) begin
                  hz.stall_IF_ID = 1'b1;
                  hz.flush_ID_EX = 1'b1;
                  cnt_nxt        = 2'd0;
                  state_nxt      = ST_DRAIN;
               end else if (ld_use || raw_haz) begin
                  hz.stall_IF_ID = 1'b1;
                  hz.stall_ID_EX = 1'b1;
                  hz.flush_ID_EX = 1'b1;
                  if (ld_use) state_nxt = ST_LD_STALL;
               end
            end
            ST_LD_STALL: begin
               if (hz.mem_busy) begin
                  hz.pipe_hold = 1'b1;
                  state_nxt    = ST_MEM_WAIT;
               end else begin
                  // The load now sits in MEM; only the no-forwarding build still has to wait.
                  if (raw_haz) begin
                     hz.stall_IF_ID = 1'b1;
                     hz.stall_ID_EX = 1'b1;
                     hz.flush_ID_EX = 1'b1;
                  end
                  state_nxt = ST_RUN;
               end
            end
            ST_MEM_WAIT: begin
               hz.pipe_hold = hz.mem_busy;
               if (!hz.mem_busy) state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
               if (hz.mem_busy) begin
                  hz.pipe_hold = 1'b1;
               end else begin
                  hz.stall_IF_ID = 1'b1;
                  if (cnt == DRAIN_CYCLES - 2'd1) begin
                     cnt_nxt   = 2'd0;
                     state_nxt = ST_HALTED;
                  end else begin
                     cnt_nxt = cnt + 2'd1;
                  end
               end
            end
            ST_HALTED: begin
               hz.pipe_hold = 1'b1;
               hz.halted    = 1'b1;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected control words queued per step and checked each cycle.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
   localparam logic [1:0] F_MEM = 2'b01;
   localparam logic [1:0] F_WB  = 2'b10;
   localparam logic       S     = 1'b0;
`else
   localparam logic [1:0] F_MEM = 2'b00;
   localparam logic [1:0] F_WB  = 2'b00;
   localparam logic       S     = 1'b1;
`endif

   // control byte order: stall_IF_ID stall_ID_EX flush_IF_ID flush_ID_EX flush_EX_MEM flush_MEM_WB pipe_hold halted
   localparam logic [7:0] C_IDLE  = 8'b0000_0000;
   localparam logic [7:0] C_STALL = 8'b1101_0000;
   localparam logic [7:0] C_BR    = 8'b0011_0000;
   localparam logic [7:0] C_HLTIN = 8'b1001_0000;
   localparam logic [7:0] C_DRAIN = 8'b1000_0000;
   localparam logic [7:0] C_HOLD  = 8'b0000_0010;
   localparam logic [7:0] C_HALT  = 8'b0000_0011;
   localparam logic [7:0] C_RSTX  = 8'b0000_1100;
   localparam logic [7:0] C_DEP   = {S, S, 1'b0, S, 4'b0000};

   logic clk, rst_n;
   int   vecs, errs;
   logic [11:0] sbq[$];

   pipeline_hazard_ctrl_if hif ();

   pipeline_hazard_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] ex(input logic [7:0] c, input logic [1:0] f1, input logic [1:0] f2);
      return {c, f1, f2};
   endfunction

   task automatic clr();
      hif.ID_src_reg1 = 5'd0;  hif.ID_src_reg2 = 5'd0;
      hif.ID_use_src1 = 1'b0;  hif.ID_use_src2 = 1'b0;  hif.ID_hlt = 1'b0;
      hif.EX_src_reg1 = 5'd0;  hif.EX_src_reg2 = 5'd0;
      hif.EX_dst_reg  = 5'd0;  hif.MEM_dst_reg = 5'd0;  hif.WB_dst_reg = 5'd0;
      hif.EX_use_dst_reg = 1'b0; hif.MEM_use_dst_reg = 1'b0; hif.WB_use_dst_reg = 1'b0;
      hif.EX_mem_read = 1'b0;  hif.EX_branch_taken = 1'b0; hif.mem_busy = 1'b0;
   endtask

   task automatic ld_use_in();
      hif.EX_mem_read = 1'b1; hif.EX_use_dst_reg = 1'b1; hif.EX_dst_reg = 5'd5;
      hif.ID_use_src1 = 1'b1; hif.ID_src_reg1 = 5'd5;
   endtask

   // Inputs are already driven; score this cycle at the falling edge, then advance one clock.
   task automatic chk(input string tag, input logic [11:0] exp_w);
      logic [11:0] obs, want;
      sbq.push_back(exp_w);
      @(negedge clk);
      want = sbq.pop_front();
      obs  = {hif.stall_IF_ID, hif.stall_ID_EX, hif.flush_IF_ID, hif.flush_ID_EX,
              hif.flush_EX_MEM, hif.flush_MEM_WB, hif.pipe_hold, hif.halted,
              hif.fwd_sel1, hif.fwd_sel2};
      vecs++;
      assert (obs === want) else begin
         errs++;
         $error("FAIL %s: got %b want %b", tag, obs, want);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      rst_n = 1'b0;
      clr();
      hif.EX_src_reg1 = 5'd3; hif.MEM_dst_reg = 5'd3; hif.MEM_use_dst_reg = 1'b1;
      chk("reset", ex(C_IDLE, F_MEM, 2'b00));
      rst_n = 1'b1;
      chk("rst_exit", ex(C_RSTX, F_MEM, 2'b00));
      hif.WB_dst_reg = 5'd3; hif.WB_use_dst_reg = 1'b1;
      chk("mem_over_wb", ex(C_IDLE, F_MEM, 2'b00));
      hif.EX_src_reg1 = 5'd0; hif.MEM_dst_reg = 5'd0; hif.EX_src_reg2 = 5'd3;
      chk("r0_and_wb", ex(C_IDLE, 2'b00, F_WB));

      // load r5; add r5 -> one stall cycle, then the add forwards from MEM
      clr(); ld_use_in();
      chk("ld_use", ex(C_STALL, 2'b00, 2'b00));
      clr();
      hif.EX_src_reg1 = 5'd5; hif.MEM_dst_reg = 5'd5; hif.MEM_use_dst_reg = 1'b1;
      hif.ID_src_reg1 = 5'd6; hif.ID_use_src1 = 1'b1;
      chk("ld_fwd", ex(C_IDLE, F_MEM, 2'b00));

      // memory wait: hold exactly while busy, no stalls in the release cycle, then RUN
      clr(); hif.mem_busy = 1'b1;
      for (int n = 0; n < 4; n++) chk("busy_hold", ex(C_HOLD, 2'b00, 2'b00));
      hif.mem_busy = 1'b0; ld_use_in();
      chk("busy_end", ex(C_IDLE, 2'b00, 2'b00));
      chk("ld_after_busy", ex(C_STALL, 2'b00, 2'b00));
      clr();
      chk("ld_stall_idle", ex(C_IDLE, 2'b00, 2'b00));

      // taken branch discards a coincident load-use and halt; FSM must still be in RUN
      ld_use_in(); hif.ID_hlt = 1'b1; hif.EX_branch_taken = 1'b1;
      chk("br_kill", ex(C_BR, 2'b00, 2'b00));
      clr(); hif.ID_hlt = 1'b1;
      chk("hlt_entry", ex(C_HLTIN, 2'b00, 2'b00));
      clr();
      chk("drain0", ex(C_DRAIN, 2'b00, 2'b00));
      hif.mem_busy = 1'b1;
      chk("drain_busy", ex(C_HOLD, 2'b00, 2'b00));
      hif.mem_busy = 1'b0;
      chk("drain1", ex(C_DRAIN, 2'b00, 2'b00));
      chk("drain2", ex(C_DRAIN, 2'b00, 2'b00));
      chk("halted", ex(C_HALT, 2'b00, 2'b00));
      hif.EX_branch_taken = 1'b1; hif.ID_hlt = 1'b1;
      chk("halted_hold", ex(C_HALT, 2'b00, 2'b00));
      clr(); rst_n = 1'b0;
      chk("rst_from_halt", ex(C_IDLE, 2'b00, 2'b00));
      rst_n = 1'b1;
      chk("rst_exit2", ex(C_RSTX, 2'b00, 2'b00));

      // RAW stalls without forwarding: MEM producer 1 cycle, EX producer 2 cycles
      hif.ID_use_src2 = 1'b1; hif.ID_src_reg2 = 5'd7;
      hif.MEM_dst_reg = 5'd7; hif.MEM_use_dst_reg = 1'b1;
      chk("mem_dep", ex(C_DEP, 2'b00, 2'b00));
      hif.MEM_use_dst_reg = 1'b0; hif.MEM_dst_reg = 5'd0;
      hif.WB_dst_reg = 5'd7; hif.WB_use_dst_reg = 1'b1;
      chk("mem_dep_wb", ex(C_IDLE, 2'b00, 2'b00));
      clr();
      hif.ID_use_src1 = 1'b1; hif.ID_src_reg1 = 5'd9;
      hif.EX_dst_reg = 5'd9; hif.EX_use_dst_reg = 1'b1;
      chk("ex_dep", ex(C_DEP, 2'b00, 2'b00));
      hif.EX_use_dst_reg = 1'b0; hif.EX_dst_reg = 5'd0;
      hif.MEM_dst_reg = 5'd9; hif.MEM_use_dst_reg = 1'b1;
      chk("ex_dep_mem", ex(C_DEP, 2'b00, 2'b00));
      hif.MEM_use_dst_reg = 1'b0; hif.MEM_dst_reg = 5'd0;
      hif.WB_dst_reg = 5'd9; hif.WB_use_dst_reg = 1'b1;
      chk("ex_dep_wb", ex(C_IDLE, 2'b00, 2'b00));
      clr();
      hif.ID_use_src1 = 1'b1; hif.ID_src_reg1 = 5'd0;
      hif.EX_dst_reg = 5'd0; hif.EX_use_dst_reg = 1'b1;
      chk("r0_no_haz", ex(C_IDLE, 2'b00, 2'b00));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have: clk  input  1  system clock; rising edge active.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: ID_src_reg1, ID_src_reg2  input  5 each  source registers of the instruction in ID.
REQ-004 SHALL have: ID_use_src1, ID_use_src2  input  1 each  ID source is actually read.
REQ-005 SHALL have: ID_hlt  input  1  the instruction in ID is a halt.
REQ-006 SHALL have: EX_src_reg1, EX_src_reg2  input  5 each  source registers of the instruction in EX.
REQ-007 SHALL have: EX_dst_reg, MEM_dst_reg, WB_dst_reg  input  5 each  destination registers.
REQ-008 SHALL have: EX_use_dst_reg, MEM_use_dst_reg, WB_use_dst_reg  input  1 each  destination write valid.
REQ-009 SHALL have: EX_mem_read  input  1  the instruction in EX is a load.
REQ-010 SHALL have: EX_branch_taken  input  1  a branch or jump resolved taken in EX.
REQ-011 SHALL have: mem_busy  input  1  data memory is not ready this cycle.
REQ-012 SHALL have: stall_IF_ID, stall_ID_EX  output  1 each  hold the PC/IF_ID register and the ID_EX register.
REQ-013 SHALL have: flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  output  1 each  bubble injection per pipeline register.
REQ-014 SHALL have: pipe_hold  output  1  freeze every pipeline register; drives the hlt inputs.
REQ-015 SHALL have: fwd_sel1, fwd_sel2  output  2 each  EX operand source: 00 regfile, 01 MEM stage, 10 WB stage.
REQ-016 SHALL have: halted  output  1  the processor has fully drained after a halt.

Function
REQ-017 SHALL treat register 0 as never hazarding and never forwarded.
REQ-018 SHALL set fwd_selN combinationally: 01 if MEM_use_dst_reg and MEM_dst_reg==EX_src_regN; else 10 if the same match holds for WB; else 00. MEM SHALL take priority over WB.
REQ-019 SHALL detect a load-use hazard when EX_mem_read, EX_use_dst_reg, and EX_dst_reg equals a used ID source. On detection: stall_IF_ID=1, stall_ID_EX=1, and flush_ID_EX=1 for exactly one cycle.
REQ-020 SHALL run a state machine with states RUN, LD_STALL, MEM_WAIT, DRAIN and HALTED.
REQ-021 RUN SHALL go to LD_STALL on a load-use hazard, to MEM_WAIT on mem_busy, and to DRAIN on ID_hlt. LD_STALL SHALL return to RUN after 1 cycle.
REQ-022 MEM_WAIT SHALL assert pipe_hold while mem_busy is high and return to RUN the cycle after it falls. No stall or flush SHALL be asserted in MEM_WAIT.
REQ-023 DRAIN SHALL assert stall_IF_ID, and flush_ID_EX for the cycle the halt enters it. A 2-bit counter SHALL count 3 cycles, then the FSM SHALL enter HALTED.
REQ-024 HALTED SHALL assert pipe_hold=1 and halted=1 permanently, until reset.
REQ-025 When EX_branch_taken, flush_IF_ID=1 and flush_ID_EX=1 for that cycle. A simultaneous load-use hazard or ID_hlt SHALL be discarded, because the ID instruction is wrong-path.
REQ-026 Priority SHALL be: mem_busy > branch flush > halt > load-use. mem_busy during DRAIN SHALL freeze the drain counter.
REQ-027 flush_EX_MEM and flush_MEM_WB SHALL be asserted only by reset-exit: high for the first cycle after rst_n deasserts, otherwise 0.

Reset
REQ-028 While rst_n is low: state=RUN, counter=0, all stall/flush outputs=0, pipe_hold=0, halted=0, and fwd_sel outputs as combinationally computed.
REQ-029 Reset asserted in any state, including HALTED, SHALL return the FSM to RUN asynchronously.

Configuration
REQ-030 Macro FORWARDING_EN defined: fwd_sel operates per REQ-018.
REQ-031 FORWARDING_EN undefined: fwd_sel outputs SHALL be tied to 00.
REQ-032 FORWARDING_EN undefined: any used ID source matching a valid EX or MEM destination SHALL stall IF_ID and ID_EX and flush ID_EX. The stall SHALL repeat each cycle until no match remains; WB matches need no stall because the regfile writes through.

Structure
REQ-033 The state encoding, the fwd_sel codes (FWD_RF, FWD_MEM, FWD_WB) and DRAIN_CYCLES=3 SHALL live in the shared cpu_pkg package.
REQ-034 Forwarding-select logic SHALL be a sub-module, fwd_unit, instantiated twice (once per operand).

Verification
REQ-035 Load r5, then add using r5 -> one cycle with stall_IF_ID=stall_ID_EX=flush_ID_EX=1, then fwd_sel1=01 (FORWARDING_EN) the next cycle.
REQ-036 MEM and WB both write r3, EX reads r3 -> fwd_sel1=01; with EX_src_reg1=0 -> fwd_sel1=00.
REQ-037 EX_branch_taken coincident with a load-use hazard -> flush_IF_ID=flush_ID_EX=1, stall outputs 0, FSM stays in RUN.
REQ-038 mem_busy high for 4 cycles -> pipe_hold high for exactly those 4 cycles, then RUN.
REQ-039 ID_hlt -> DRAIN for 3 cycles, then halted=1 and pipe_hold=1 held. rst_n pulse -> RUN, halted=0.
REQ-040 FORWARDING_EN undefined, dependency on the MEM dst -> a one-cycle stall; dependency on the EX dst -> a two-cycle stall.
